// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller.
// Holds the FSM state enum, opcode and R-type funct constants, the ALU
// control encoding, and the 2-bit ALU operation class used between the FSM
// and the ALU decoder.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_BNEEX,
        S_ORIEX,
        S_ADDIEX,
        S_IMMWB,
        S_JEX
    } state_t;

    // ALU operation class requested by the FSM; FUNCT defers to the funct field.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle.
// Datapath-to-controller: op, funct (from the instruction register), zero
// (ALU flag), memready (memory access completes this cycle).
// Controller-to-datapath: strobes, mux selects, pcen, alucontrol, and the
// instr_done / illegal_op status pulses.
// slave = controller side, master = datapath side.
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;

    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        output op, funct, zero, memready,
        input  memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
               alusrcb, pcsrc, pcen, alucontrol, instr_done, illegal_op
    );

    modport slave (
        input  op, funct, zero, memready,
        output memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
               alusrcb, pcsrc, pcen, alucontrol, instr_done, illegal_op
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's ALU operation class plus the R-type funct
// field onto the 3-bit alucontrol code.
// Ports: funct (in, 6), aluop (in, aluop_t), alucontrol (out, 3),
//        funct_valid (out, 1: funct is one of the supported R-type ops).
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] funct,
    input  aluop_t     aluop,
    output logic [2:0] alucontrol,
    output logic       funct_valid
);

    logic [2:0] funct_alu;

    always_comb begin
        funct_valid = 1'b1;
        funct_alu   = ALU_ADD;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD:   alucontrol = ALU_ADD;
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_OR:    alucontrol = ALU_OR;
            ALUOP_FUNCT: alucontrol = funct_alu;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset controller FSM.
// Ports: clk, reset (synchronous, active-high), bus (slave modport of
// multicycle_controller_if). All outputs are combinational from the current
// state and the live op/funct/zero/memready inputs.
// MEM_WAIT_EN=1 makes FETCH/MEMRD/MEMWR stall on memready; 0 treats
// memready as always high. EXT_OPS_EN=0 makes bne and ori illegal.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b0,
    parameter bit EXT_OPS_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_controller_if.slave bus
);

    state_t state_reg, state_next;
    state_t decode_next;
    aluop_t aluop;
    logic   funct_valid;
    logic   op_legal;
    logic   mem_ok;

    assign mem_ok = MEM_WAIT_EN ? bus.memready : 1'b1;

    alu_decoder u_alu_decoder (
        .funct       (bus.funct),
        .aluop       (aluop),
        .alucontrol  (bus.alucontrol),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_FETCH;
        else       state_reg <= state_next;
    end

    // Opcode dispatch out of DECODE; an unsupported funct makes an R-type illegal.
    always_comb begin
        op_legal    = 1'b1;
        decode_next = S_FETCH;
        case (bus.op)
            OP_LW, OP_SW: decode_next = S_MEMADR;
            OP_RTYPE: begin
                decode_next = S_RTYPEEX;
                op_legal    = funct_valid;
            end
            OP_BEQ:  decode_next = S_BEQEX;
            OP_BNE: begin
                decode_next = S_BNEEX;
                op_legal    = EXT_OPS_EN;
            end
            OP_ADDI: decode_next = S_ADDIEX;
            OP_ORI: begin
                decode_next = S_ORIEX;
                op_legal    = EXT_OPS_EN;
            end
            OP_J:    decode_next = S_JEX;
            default: op_legal = 1'b0;
        endcase
        if (!op_legal) decode_next = S_FETCH;
    end

    always_comb begin
        state_next      = state_reg;
        aluop           = ALUOP_ADD;
        bus.memwrite    = 1'b0;
        bus.irwrite     = 1'b0;
        bus.regwrite    = 1'b0;
        bus.iord        = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.regdst      = 1'b0;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = 2'b00;
        bus.pcsrc       = 2'b00;
        bus.pcen        = 1'b0;
        bus.instr_done  = 1'b0;
        bus.illegal_op  = 1'b0;

        case (state_reg)
            S_FETCH: begin
                bus.alusrcb = 2'b01;
                bus.irwrite = mem_ok;
                bus.pcen    = mem_ok;
                if (mem_ok) state_next = S_DECODE;
            end
            S_DECODE: begin
                bus.alusrcb    = 2'b11;
                bus.illegal_op = !op_legal;
                bus.instr_done = !op_legal;
                state_next     = decode_next;
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_next  = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                if (mem_ok) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                bus.memtoreg   = 1'b1;
                bus.regwrite   = 1'b1;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEMWR: begin
                // memwrite stays high for the whole stall; done only on the last cycle
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
                if (mem_ok) begin
                    bus.instr_done = 1'b1;
                    state_next     = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_FUNCT;
                state_next  = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                bus.regdst     = 1'b1;
                bus.regwrite   = 1'b1;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_BEQEX, S_BNEEX: begin
                bus.alusrca    = 1'b1;
                aluop          = ALUOP_SUB;
                bus.pcsrc      = 2'b01;
                bus.pcen       = (state_reg == S_BEQEX) ? bus.zero : !bus.zero;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_ADDIEX, S_ORIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                aluop       = (state_reg == S_ORIEX) ? ALUOP_OR : ALUOP_ADD;
                state_next  = S_IMMWB;
            end
            S_IMMWB: begin
                bus.regwrite   = 1'b1;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_JEX: begin
                bus.pcsrc      = 2'b10;
                bus.pcen       = 1'b1;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase

        // No side effects may reach the datapath while reset is held.
        if (reset) begin
            bus.memwrite   = 1'b0;
            bus.irwrite    = 1'b0;
            bus.regwrite   = 1'b0;
            bus.pcen       = 1'b0;
            bus.instr_done = 1'b0;
            bus.illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [2:0] alucontrol;
        logic       instr_done;
        logic       illegal_op;
    } outs_t;

    // One expected phase of an instruction; mem phases repeat 'wt' while memory stalls.
    typedef struct {
        outs_t wt;
        outs_t dn;
        bit    mem;
    } step_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cpi;
        int         regw;
        int         memw;
        int         ill;
        int         pcen;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if bus_a ();
    multicycle_controller_if bus_b ();

    multicycle_controller #(.MEM_WAIT_EN(1'b1), .EXT_OPS_EN(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    multicycle_controller #(.MEM_WAIT_EN(1'b0), .EXT_OPS_EN(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    outs_t act_a, act_b;
    assign act_a = {bus_a.memwrite, bus_a.irwrite, bus_a.regwrite, bus_a.iord, bus_a.memtoreg,
                    bus_a.regdst, bus_a.alusrca, bus_a.alusrcb, bus_a.pcsrc, bus_a.pcen,
                    bus_a.alucontrol, bus_a.instr_done, bus_a.illegal_op};
    assign act_b = {bus_b.memwrite, bus_b.irwrite, bus_b.regwrite, bus_b.iord, bus_b.memtoreg,
                    bus_b.regdst, bus_b.alusrca, bus_b.alusrcb, bus_b.pcsrc, bus_b.pcen,
                    bus_b.alucontrol, bus_b.instr_done, bus_b.illegal_op};

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    sel;
    bit    wait_en;
    bit    ext_en;
    step_t steps[$];
    int    r_cycles, r_regw, r_memw, r_ill, r_pcen, r_done;
    vec_t  tbl[16];

    function automatic outs_t idle();
        outs_t o;
        o = '0;
        o.alucontrol = 3'b010;
        return o;
    endfunction

    function automatic outs_t actual();
        return sel ? act_b : act_a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic mr);
        @(posedge clk);
        #1;
        reset          = rst;
        bus_a.op       = op;  bus_b.op       = op;
        bus_a.funct    = fn;  bus_b.funct    = fn;
        bus_a.zero     = z;   bus_b.zero     = z;
        bus_a.memready = mr;  bus_b.memready = mr;
        @(negedge clk);
    endtask

    function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_R)
            return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        if (op == OP_BNE || op == OP_ORI) return ext_en;
        return op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

    task automatic add(input outs_t wt, input outs_t dn, input bit mem);
        step_t s;
        s.wt = wt; s.dn = dn; s.mem = mem;
        steps.push_back(s);
    endtask

    // Expected observable behaviour of one instruction, phase by phase.
    task automatic plan(input logic [5:0] op, input logic [5:0] fn, input logic z);
        outs_t f, d, e, w;
        steps.delete();
        f = idle(); f.alusrcb = 2'b01;
        e = f; e.irwrite = 1'b1; e.pcen = 1'b1;
        add(f, e, 1'b1);
        d = idle(); d.alusrcb = 2'b11;
        if (!legal(op, fn)) begin
            d.illegal_op = 1'b1; d.instr_done = 1'b1;
            add(d, d, 1'b0);
            return;
        end
        add(d, d, 1'b0);
        case (op)
            OP_LW, OP_SW: begin
                e = idle(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
                add(e, e, 1'b0);
                if (op == OP_LW) begin
                    w = idle(); w.iord = 1'b1;
                    add(w, w, 1'b1);
                    w = idle(); w.memtoreg = 1'b1; w.regwrite = 1'b1; w.instr_done = 1'b1;
                    add(w, w, 1'b0);
                end else begin
                    w = idle(); w.iord = 1'b1; w.memwrite = 1'b1;
                    e = w; e.instr_done = 1'b1;
                    add(w, e, 1'b1);
                end
            end
            OP_R: begin
                e = idle(); e.alusrca = 1'b1; e.alucontrol = rtype_alu(fn);
                add(e, e, 1'b0);
                w = idle(); w.regdst = 1'b1; w.regwrite = 1'b1; w.instr_done = 1'b1;
                add(w, w, 1'b0);
            end
            OP_BEQ, OP_BNE: begin
                e = idle(); e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
                e.pcen = (op == OP_BEQ) ? z : !z;
                e.instr_done = 1'b1;
                add(e, e, 1'b0);
            end
            OP_ADDI, OP_ORI: begin
                e = idle(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
                e.alucontrol = (op == OP_ORI) ? 3'b001 : 3'b010;
                add(e, e, 1'b0);
                w = idle(); w.regwrite = 1'b1; w.instr_done = 1'b1;
                add(w, w, 1'b0);
            end
            default: begin
                e = idle(); e.pcsrc = 2'b10; e.pcen = 1'b1; e.instr_done = 1'b1;
                add(e, e, 1'b0);
            end
        endcase
    endtask

    // Runs one instruction; memready comes from pat[cycle] or randomly, and is
    // forced high after 30 cycles so every instruction terminates.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input bit rnd, input logic [31:0] pat);
        int    idx;
        logic  mr;
        bit    eff;
        outs_t exp, act;
        plan(op, fn, z);
        idx = 0;
        r_cycles = 0; r_regw = 0; r_memw = 0; r_ill = 0; r_pcen = 0; r_done = 0;
        while (idx < steps.size()) begin
            if (r_cycles >= 30)  mr = 1'b1;
            else if (rnd)        mr = ($urandom_range(0, 2) != 0);
            else                 mr = pat[r_cycles];
            drive(1'b0, op, fn, z, mr);
            eff = !wait_en || mr;
            exp = (steps[idx].mem && !eff) ? steps[idx].wt : steps[idx].dn;
            act = actual();
            chk("cycle_outputs", 32'(act), 32'(exp));
            if (act.regwrite === 1'b1)   r_regw++;
            if (act.memwrite === 1'b1)   r_memw++;
            if (act.illegal_op === 1'b1) r_ill++;
            if (act.pcen === 1'b1)       r_pcen++;
            if (act.instr_done === 1'b1) r_done++;
            if (!steps[idx].mem || eff) idx++;
            r_cycles++;
        end
        chk("instr_done_count", r_done, 1);
        $display("instr dut=%s op=%b funct=%b zero=%b cycles=%0d",
                 sel ? "B" : "A", op, fn, z, r_cycles);
    endtask

    task automatic do_reset();
        outs_t exp;
        drive(1'b1, OP_R, 6'd0, 1'b0, 1'b1);
        drive(1'b1, OP_R, 6'd0, 1'b0, 1'b1);
        exp = idle(); exp.alusrcb = 2'b01;
        chk("reset_outputs", 32'(actual()), 32'(exp));
    endtask

    task automatic run_random(input int n);
        logic [5:0] op, fn;
        logic [5:0] ops [10];
        logic [5:0] fns [5];
        ops = '{OP_R, OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J, OP_BAD};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int i = 0; i < n; i++) begin
            op = ops[$urandom_range(0, 9)];
            if (op == OP_BAD) op = 6'($urandom_range(0, 63));
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
            run_instr(op, fn, 1'($urandom_range(0, 1)), 1'b1, 32'd0);
        end
    endtask

    initial begin
        outs_t a, exp;

        //            op       funct       z     cpi regw memw ill pcen
        tbl[0]  = '{OP_R,    6'b100000, 1'b0, 4, 1, 0, 0, 1};
        tbl[1]  = '{OP_R,    6'b100010, 1'b0, 4, 1, 0, 0, 1};
        tbl[2]  = '{OP_R,    6'b100100, 1'b0, 4, 1, 0, 0, 1};
        tbl[3]  = '{OP_R,    6'b100101, 1'b0, 4, 1, 0, 0, 1};
        tbl[4]  = '{OP_R,    6'b101010, 1'b0, 4, 1, 0, 0, 1};
        tbl[5]  = '{OP_R,    6'b000111, 1'b0, 2, 0, 0, 1, 1};
        tbl[6]  = '{OP_LW,   6'b000000, 1'b0, 5, 1, 0, 0, 1};
        tbl[7]  = '{OP_SW,   6'b000000, 1'b0, 4, 0, 1, 0, 1};
        tbl[8]  = '{OP_BEQ,  6'b000000, 1'b1, 3, 0, 0, 0, 2};
        tbl[9]  = '{OP_BEQ,  6'b000000, 1'b0, 3, 0, 0, 0, 1};
        tbl[10] = '{OP_BNE,  6'b000000, 1'b1, 3, 0, 0, 0, 1};
        tbl[11] = '{OP_BNE,  6'b000000, 1'b0, 3, 0, 0, 0, 2};
        tbl[12] = '{OP_ADDI, 6'b000000, 1'b0, 4, 1, 0, 0, 1};
        tbl[13] = '{OP_ORI,  6'b000000, 1'b0, 4, 1, 0, 0, 1};
        tbl[14] = '{OP_J,    6'b000000, 1'b0, 3, 0, 0, 0, 2};
        tbl[15] = '{OP_BAD,  6'b000000, 1'b0, 2, 0, 0, 1, 1};

        reset = 1'b1;
        sel = 1'b0; wait_en = 1'b1; ext_en = 1'b1;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            run_instr(tbl[i].op, tbl[i].funct, tbl[i].zero, 1'b0, 32'hFFFF_FFFF);
            chk("table_cpi",      r_cycles, tbl[i].cpi);
            chk("table_regwrite", r_regw,   tbl[i].regw);
            chk("table_memwrite", r_memw,   tbl[i].memw);
            chk("table_illegal",  r_ill,    tbl[i].ill);
            chk("table_pcen",     r_pcen,   tbl[i].pcen);
        end

        // lw with memready low for two MEMRD cycles
        run_instr(OP_LW, 6'd0, 1'b0, 1'b0, 32'hFFFF_FF67);
        chk("lw_wait_cpi", r_cycles, 7);
        chk("lw_wait_regwrite", r_regw, 1);
        // add with one FETCH stall
        run_instr(OP_R, 6'b100000, 1'b0, 1'b0, 32'hFFFF_FFFE);
        chk("fetch_wait_cpi", r_cycles, 5);
        // sw with one MEMWR stall: memwrite held on both cycles
        run_instr(OP_SW, 6'd0, 1'b0, 1'b0, 32'hFFFF_FFF7);
        chk("sw_wait_cpi", r_cycles, 5);
        chk("sw_wait_memwrite", r_memw, 2);

        // reset in the middle of a stalled store
        drive(1'b0, OP_SW, 6'd0, 1'b0, 1'b1);
        a = actual();
        chk("mwr_fetch_irwrite", 32'(a.irwrite), 1);
        drive(1'b0, OP_SW, 6'd0, 1'b0, 1'b1);
        drive(1'b0, OP_SW, 6'd0, 1'b0, 1'b1);
        drive(1'b0, OP_SW, 6'd0, 1'b0, 1'b0);
        a = actual();
        chk("mwr_memwrite", 32'(a.memwrite), 1);
        chk("mwr_no_done", 32'(a.instr_done), 0);
        drive(1'b1, OP_SW, 6'd0, 1'b0, 1'b0);
        a = actual();
        chk("mwr_reset_strobes",
            32'({a.memwrite, a.irwrite, a.regwrite, a.pcen, a.instr_done, a.illegal_op}), 0);
        drive(1'b0, OP_SW, 6'd0, 1'b0, 1'b0);
        exp = idle(); exp.alusrcb = 2'b01;
        chk("mwr_after_reset_fetch", 32'(actual()), 32'(exp));
        do_reset();

        run_random(60);

        // second configuration: no memory waits, extended ops disabled
        sel = 1'b1; wait_en = 1'b0; ext_en = 1'b0;
        do_reset();
        run_instr(OP_ORI, 6'd0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        chk("noext_ori_cpi", r_cycles, 2);
        chk("noext_ori_illegal", r_ill, 1);
        chk("noext_ori_regwrite", r_regw, 0);
        run_instr(OP_BNE, 6'd0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        chk("noext_bne_illegal", r_ill, 1);
        chk("noext_bne_pcen", r_pcen, 1);
        run_instr(OP_LW, 6'd0, 1'b0, 1'b0, 32'h0000_0000);
        chk("nowait_lw_cpi", r_cycles, 5);
        run_instr(OP_SW, 6'd0, 1'b0, 1'b0, 32'h0000_0000);
        chk("nowait_sw_cpi", r_cycles, 4);
        chk("nowait_sw_memwrite", r_memw, 1);

        run_random(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 MEM_WAIT_EN, default 0, 1 = FETCH/MEMRD/MEMWR hold until memready=1; 0 = memready ignored, treated as 1.
REQ-002 EXT_OPS_EN, default 1, 1 = bne and ori decoded; 0 = both illegal.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 op  input  6  instruction opcode, from instruction register.
REQ-006 funct  input  6  R-type function field.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 memready  input  1  memory access completes this cycle.
REQ-009 memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca  output  1 each  datapath strobes/selects.
REQ-010 alusrcb  output  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 imm<<2.
REQ-011 pcsrc  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 pcen  output  1  PC write enable.
REQ-013 alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-014 instr_done  output  1  one-cycle pulse on last state of each instruction.
REQ-015 illegal_op  output  1  one-cycle pulse in DECODE on unsupported op/funct.

Function
REQ-016 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, ORIEX, ADDIEX, IMMWB, JEX.
REQ-017 FETCH: iord=0, alusrca=0, alusrcb=01, aluop add, pcsrc=00; irwrite and pcen = memready; ->DECODE when memready, else hold.
REQ-018 DECODE: alusrca=0, alusrcb=11, add; next by op: 100011/101011->MEMADR, 000000->RTYPEEX, 000100->BEQEX, 000101->BNEEX, 001000->ADDIEX, 001101->ORIEX, 000010->JEX, other->FETCH with illegal_op=1.
REQ-019 MEMADR: alusrca=1, alusrcb=10, add; lw->MEMRD, sw->MEMWR.
REQ-020 MEMRD: iord=1; ->MEMWB when memready, else hold.
REQ-021 MEMWB: regdst=0, memtoreg=1, regwrite=1; ->FETCH.
REQ-022 MEMWR: iord=1, memwrite=1 every cycle in state; ->FETCH when memready, else hold.
REQ-023 RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); ->RTYPEWB.
REQ-024 Unsupported funct with op=000000: illegal_op=1 in DECODE, ->FETCH, no register write.
REQ-025 RTYPEWB: regdst=1, memtoreg=0, regwrite=1; ->FETCH.
REQ-026 BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero; BNEEX identical with pcen=~zero; both ->FETCH.
REQ-027 ADDIEX: alusrca=1, alusrcb=10, add; ORIEX same with or; both ->IMMWB.
REQ-028 IMMWB: regdst=0, memtoreg=0, regwrite=1; ->FETCH.
REQ-029 JEX: pcsrc=10, pcen=1; ->FETCH.
REQ-030 Outputs not listed for a state are 0; alucontrol defaults to 010.
REQ-031 instr_done=1 in MEMWB, RTYPEWB, IMMWB, BEQEX, BNEEX, JEX, MEMWR-with-memready, and illegal DECODE.
REQ-032 Outputs are combinational from state, op, funct, zero, memready; no output registered.
REQ-033 CPI: R-type/addi/ori 4, beq/bne/j 3, sw 4, lw 5, each memory wait cycle adding 1.

Reset
REQ-034 reset=1 at any clk edge forces FETCH, overriding any pending transition or memory wait.
REQ-035 During reset all strobes (memwrite, irwrite, regwrite, pcen, instr_done, illegal_op) SHALL be 0.

Structure
REQ-036 Shared package holds state enum, opcode/funct constants, alucontrol encoding, 2-bit aluop type.
REQ-037 Sub-module alu_decoder (funct, aluop -> alucontrol, funct_valid); FSM in this module.

Verification
REQ-038 reset, then add (op 000000, funct 100000), memready=1 -> states F,D,RTYPEEX,RTYPEWB; regwrite=1, regdst=1 cycle 4; instr_done cycle 4.
REQ-039 MEM_WAIT_EN=1, lw, memready low 2 cycles in MEMRD -> MEMRD held 3 cycles, regwrite+memtoreg one cycle after memready.
REQ-040 beq zero=1 -> pcen=1, pcsrc=01 in BEQEX; bne zero=1 -> pcen=0.
REQ-041 op=111111 -> illegal_op pulse in DECODE, next state FETCH, no regwrite/memwrite.
REQ-042 reset asserted mid-MEMWR with memready=0 -> FETCH next cycle, memwrite=0 during reset.
REQ-043 EXT_OPS_EN=0, ori (001101) -> illegal_op=1, no regwrite.
